// File: rtl/cacheline_adaptor.sv
// Cache line adaptor between the cache arbiter and the physical memory port.
// Turns one full-line read or write request into a BEATS-long burst on the
// narrow memory bus. When the whole line has moved, it returns a one-cycle
// resp_o pulse to the arbiter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   address_i             line address from arbiter (low offset bits ignored)
//   read_i / write_i      line read / write request, held until resp_o
//   line_i                write line from arbiter
//   line_o                assembled read line (valid while resp_o is high)
//   resp_o                one-cycle transfer-complete pulse
//   address_o             line-aligned address to memory
//   read_o / write_o      burst read / write request to memory
//   burst_o               write beat to memory
//   burst_i               read beat from memory
//   resp_i                memory beat strobe, one beat per high cycle
module cacheline_adaptor #(
   parameter int unsigned LINE_WIDTH  = 256,
   parameter int unsigned BURST_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   output logic                   resp_o,
   output logic [ADDR_WIDTH-1:0]  address_o,
   output logic                   read_o,
   output logic                   write_o,
   output logic [BURST_WIDTH-1:0] burst_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   input  logic                   resp_i
);

   localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
   localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam int unsigned CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
      ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   state_e                             state_q;
   logic [CNT_W-1:0]                   cnt_q;
   logic [BEATS-1:0][BURST_WIDTH-1:0]  line_q;
   logic [BEATS-1:0][BURST_WIDTH-1:0]  wbuf_q;

   logic [ADDR_WIDTH-1:0] addr_aligned;
   logic [CNT_W-1:0]      cnt_next;
   logic                  last_beat;

   assign addr_aligned = address_i & ~OFFSET_MASK;
   assign cnt_next     = cnt_q + CNT_ONE;
   assign last_beat    = (cnt_q == LAST_BEAT);

   // The beat-sliced view of the line register is the arbiter's read line.
   assign line_o = line_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         line_q    <= '0;
         wbuf_q    <= '0;
         burst_o   <= '0;
         address_o <= '0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         resp_o    <= 1'b0;
      end else begin
         resp_o <= 1'b0;
         case (state_q)
            StIdle: begin
               // Read has priority if both requests arrive together.
               if (read_i) begin
                  address_o <= addr_aligned;
                  cnt_q     <= '0;
                  read_o    <= 1'b1;
                  state_q   <= StRead;
               end else if (write_i) begin
                  address_o <= addr_aligned;
                  wbuf_q    <= line_i;
                  // Beat 0 comes straight from line_i, so it is on the bus with write_o.
                  burst_o   <= line_i[BURST_WIDTH-1:0];
                  cnt_q     <= '0;
                  write_o   <= 1'b1;
                  state_q   <= StWrite;
               end
            end

            StRead: begin
               if (resp_i) begin
                  line_q[cnt_q] <= burst_i;
                  if (last_beat) begin
                     cnt_q   <= '0;
                     read_o  <= 1'b0;
                     resp_o  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     cnt_q <= cnt_next;
                  end
               end
            end

            StWrite: begin
               if (resp_i) begin
                  if (last_beat) begin
                     cnt_q   <= '0;
                     write_o <= 1'b0;
                     resp_o  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     cnt_q   <= cnt_next;
                     burst_o <= wbuf_q[cnt_next];
                  end
               end
            end

            // Requests are not sampled here, so a request still held high
            // during the resp_o cycle cannot start a second transfer.
            StDone: begin
               state_q <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, writes with gaps, held requests,
// async reset mid-burst, spurious memory strobes and back-to-back transfers.
module tb_cacheline_adaptor;

   localparam int LW = 256;
   localparam int BW = 64;
   localparam int AW = 32;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] address_i;
   logic          read_i;
   logic          write_i;
   logic [LW-1:0] line_i;
   logic [LW-1:0] line_o;
   logic          resp_o;
   logic [AW-1:0] address_o;
   logic          read_o;
   logic          write_o;
   logic [BW-1:0] burst_o;
   logic [BW-1:0] burst_i;
   logic          resp_i;

   int vectors     = 0;
   int miscompares = 0;

   cacheline_adaptor #(
      .LINE_WIDTH (LW),
      .BURST_WIDTH(BW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .address_i(address_i),
      .read_i   (read_i),
      .write_i  (write_i),
      .line_i   (line_i),
      .line_o   (line_o),
      .resp_o   (resp_o),
      .address_o(address_o),
      .read_o   (read_o),
      .write_o  (write_o),
      .burst_o  (burst_o),
      .burst_i  (burst_i),
      .resp_i   (resp_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line images, beat 0 in the low slot.
   localparam logic [LW-1:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [LW-1:0] L2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                   64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0};
   localparam logic [LW-1:0] L3 = {64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002,
                                   64'hCAFE_0001_CAFE_0001, 64'hCAFE_0000_CAFE_0000};
   localparam logic [BW-1:0] D0 = 64'hD000_0000_0000_00D0;
   localparam logic [BW-1:0] D1 = 64'hD111_1111_1111_11D1;
   localparam logic [BW-1:0] D2 = 64'hD222_2222_2222_22D2;
   localparam logic [BW-1:0] D3 = 64'hD333_3333_3333_33D3;
   localparam logic [BW-1:0] E0 = 64'hE000_0000_0000_00E0;
   localparam logic [BW-1:0] E1 = 64'hE111_1111_1111_11E1;
   localparam logic [BW-1:0] E2 = 64'hE222_2222_2222_22E2;
   localparam logic [BW-1:0] E3 = 64'hE333_3333_3333_33E3;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues a read and feeds four back-to-back beats. Returns in the DONE cycle
   // with read_i still high, so the caller chooses when to drop it.
   task automatic run_read(input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                           input logic [LW-1:0] line, input string tag);
      read_i    = 1'b1;
      address_i = addr;
      tick();
      for (int b = 0; b < 4; b++) begin
         chk({tag, " read_o beat"}, LW'(read_o), LW'(1'b1));
         chk({tag, " resp_o early"}, LW'(resp_o), LW'(1'b0));
         chk({tag, " address_o"}, LW'(address_o), LW'(exp_addr));
         resp_i  = 1'b1;
         burst_i = line[b*BW +: BW];
         tick();
      end
      resp_i  = 1'b0;
      burst_i = '0;
      chk({tag, " read_o done"}, LW'(read_o), LW'(1'b0));
      chk({tag, " resp_o done"}, LW'(resp_o), LW'(1'b1));
      chk({tag, " line_o"}, line_o, line);
   endtask

   logic [BW-1:0] wexp [7];
   logic          wpat [7];

   initial begin
      rst_n     = 1'b1;
      address_i = '0;
      read_i    = 1'b0;
      write_i   = 1'b0;
      line_i    = '0;
      burst_i   = '0;
      resp_i    = 1'b0;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("reset read_o", LW'(read_o), '0);
      chk("reset write_o", LW'(write_o), '0);
      chk("reset resp_o", LW'(resp_o), '0);
      chk("reset address_o", LW'(address_o), '0);
      chk("reset burst_o", LW'(burst_o), '0);
      chk("reset line_o", line_o, '0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: read with no gaps, resp_o a single pulse, line_o held afterwards
      run_read(32'h0000_1234, 32'h0000_1220, L1, "rd1");
      read_i = 1'b0;
      tick();
      chk("rd1 resp_o one cycle", LW'(resp_o), '0);
      chk("rd1 line_o held", line_o, L1);
      tick();

      // 2: write with gaps in the memory strobe
      write_i   = 1'b1;
      address_i = 32'h0000_ABCD;
      line_i    = {D3, D2, D1, D0};
      tick();
      line_i    = {LW{1'b1}};
      chk("wr address_o", LW'(address_o), LW'(32'h0000_ABC0));
      wpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      wexp = '{D0, D1, D1, D2, D2, D2, D3};
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("wr burst_o cycle %0d", k), LW'(burst_o), LW'(wexp[k]));
         chk($sformatf("wr write_o cycle %0d", k), LW'(write_o), LW'(1'b1));
         chk($sformatf("wr resp_o cycle %0d", k), LW'(resp_o), '0);
         resp_i = wpat[k];
         tick();
      end
      resp_i = 1'b0;
      chk("wr write_o done", LW'(write_o), '0);
      chk("wr resp_o done", LW'(resp_o), LW'(1'b1));
      write_i = 1'b0;
      tick();
      chk("wr resp_o one cycle", LW'(resp_o), '0);
      chk("wr line_o untouched", line_o, L1);
      tick();

      // 3: read_i held through DONE, dropped one cycle later
      run_read(32'h0000_2000, 32'h0000_2000, L2, "rd3");
      tick();
      read_i = 1'b0;
      chk("rd3 idle resp_o", LW'(resp_o), '0);
      chk("rd3 idle read_o", LW'(read_o), '0);
      tick();
      chk("rd3 no retrigger a", LW'(read_o), '0);
      tick();
      chk("rd3 no retrigger b", LW'(read_o), '0);

      // 4: async reset after 2 of 4 beats
      read_i    = 1'b1;
      address_i = 32'h0000_3040;
      tick();
      resp_i  = 1'b1;
      burst_i = L3[0 +: BW];
      tick();
      burst_i = L3[BW +: BW];
      tick();
      resp_i = 1'b0;
      chk("rst4 read_o mid", LW'(read_o), LW'(1'b1));
      #1 rst_n = 1'b0;
      #1;
      chk("rst4 read_o async", LW'(read_o), '0);
      chk("rst4 resp_o async", LW'(resp_o), '0);
      chk("rst4 line_o async", line_o, '0);
      chk("rst4 address_o async", LW'(address_o), '0);
      read_i = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst4 idle after release", LW'(read_o), '0);
      run_read(32'h0000_3040, 32'h0000_3040, L3, "rd4");
      read_i = 1'b0;
      tick();

      // 5: spurious resp_i in IDLE, then a read still needs four beats
      resp_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("spur resp_o %0d", k), LW'(resp_o), '0);
         chk($sformatf("spur read_o %0d", k), LW'(read_o), '0);
      end
      run_read(32'h0000_1234, 32'h0000_1220, L2, "rd5");
      read_i = 1'b0;
      tick();

      // 6: read then write back-to-back
      run_read(32'h0000_4488, 32'h0000_4480, L1, "rd6");
      read_i    = 1'b0;
      write_i   = 1'b1;
      address_i = 32'h0000_5577;
      line_i    = {E3, E2, E1, E0};
      tick();
      chk("b2b idle write_o", LW'(write_o), '0);
      chk("b2b idle resp_o", LW'(resp_o), '0);
      chk("b2b idle read_o", LW'(read_o), '0);
      tick();
      chk("b2b write_o", LW'(write_o), LW'(1'b1));
      chk("b2b address_o", LW'(address_o), LW'(32'h0000_5560));
      resp_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("b2b burst_o %0d", k), LW'(burst_o), LW'(line_i[k*BW +: BW]));
         tick();
      end
      resp_i  = 1'b0;
      write_i = 1'b0;
      chk("b2b resp_o", LW'(resp_o), LW'(1'b1));
      chk("b2b write_o done", LW'(write_o), '0);
      tick();
      chk("b2b resp_o one cycle", LW'(resp_o), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
